systolic_ctrl: RTL and testbench

Sequencer for an N×N PE systolic array computing one matrix-product tile of depth k_len. It clears the array accumulators, issues skewed operand-buffer read addresses per array row and column lane, gates the array enable around operand-buffer stalls, and signals completion once every PE holds its final sum. It sits between the attention top-level FSM (start/done) and the PE array plus its edge operand buffers.

---
 rtl/systolic_pkg.sv | 34 +++
 rtl/systolic_if.sv | 30 +++
 rtl/systolic_skew_addr_gen.sv | 51 +++++
 rtl/systolic_ctrl.sv | 111 +++++++++++
 tb/tb_systolic_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants, state encoding and helpers for the
// systolic array sequencer.
//   N    array dimension (rows = columns = operand lanes)
//   KMAX maximum tile depth
//   AW   operand-buffer address width
//   KW   tile-depth width (must hold KMAX itself)
//   SW   step-counter width (must hold KMAX + 2N - 3)
package systolic_pkg;

  localparam int N    = 4;
  localparam int KMAX = 64;
  localparam int AW   = $clog2(KMAX);
  localparam int KW   = $clog2(KMAX + 1);
  localparam int SW   = $clog2(KMAX + 2 * N);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Final step index: the last lane starts N-1 steps late, and the far
  // corner PE sees its last operand another N-1 steps after that.
  function automatic logic [SW-1:0] last_step(input logic [KW-1:0] k);
    return SW'(k) + SW'(2 * N - 3);
  endfunction

  function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
    return (k > KW'(KMAX)) ? KW'(KMAX) : k;
  endfunction

endpackage

// File: rtl/systolic_if.sv
// systolic_if: bundle between the sequencer and the PE array plus its edge
// operand buffers.
//   src_valid  buffers can serve a read this cycle
//   rd_en      buffer read strobe (advance)
//   lane_addr  per-lane buffer address, lane i at [i*AW +: AW]
//   lane_vld   per-lane address valid (datapath feeds zero when low)
//   pe_en      array enable
//   pe_rst_n   array accumulator clear, active-low
// master = sequencer side, slave = array/buffer side.
interface systolic_if;
  import systolic_pkg::*;

  logic              src_valid;
  logic              rd_en;
  logic [N*AW-1:0]   lane_addr;
  logic [N-1:0]      lane_vld;
  logic              pe_en;
  logic              pe_rst_n;

  modport master (
    input  src_valid,
    output rd_en, lane_addr, lane_vld, pe_en, pe_rst_n
  );

  modport slave (
    output src_valid,
    input  rd_en, lane_addr, lane_vld, pe_en, pe_rst_n
  );

endinterface

// File: rtl/systolic_skew_addr_gen.sv
// skew_addr_gen: maps a step count and tile depth to skewed per-lane
// operand addresses, registered.
//   i_clk        clock
//   i_rst_n      synchronous active-low reset
//   i_load       1: capture addresses for i_step, 0: force outputs to zero
//   i_step       step count the outputs should reflect next cycle
//   i_k_len      latched tile depth
//   o_lane_addr  lane i address at [i*AW +: AW]
//   o_lane_vld   lane i valid
module skew_addr_gen
  import systolic_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [SW-1:0]     i_step,
  input  logic [KW-1:0]     i_k_len,
  output logic [N*AW-1:0]   o_lane_addr,
  output logic [N-1:0]      o_lane_vld
);

  logic [N*AW-1:0] w_addr;
  logic [N-1:0]    w_vld;
  logic [N*AW-1:0] r_addr;
  logic [N-1:0]    r_vld;

  // Lane g lags the step by g; its address is only meaningful while the
  // lagged index falls inside [0, k_len).
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [SW-1:0] w_diff;
    logic          w_in;
    assign w_diff = i_step - SW'(g);
    assign w_in   = (i_step >= SW'(g)) && (w_diff < SW'(i_k_len));
    assign w_vld[g]              = w_in;
    assign w_addr[g*AW +: AW]    = w_in ? w_diff[AW-1:0] : '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_load) begin
      r_addr <= '0;
      r_vld  <= '0;
    end else begin
      r_addr <= w_addr;
      r_vld  <= w_vld;
    end
  end

  assign o_lane_addr = r_addr;
  assign o_lane_vld  = r_vld;

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for an N x N systolic PE array computing one
// matrix-product tile. Clears the accumulators, walks a step counter that
// drives skewed operand-buffer addresses, stalls on src_valid, and pulses
// done once every PE holds its final sum.
//   i_clk     clock
//   i_rst_n   synchronous active-low reset
//   i_start   begin a tile (sampled only in IDLE)
//   i_k_len   tile depth, latched and clamped to KMAX on accepted start
//   o_busy    sequencer not idle
//   o_done    one-cycle completion pulse
//   io_arr    array / operand-buffer bundle (master side)
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | accumulators cleared (pe_rst_n low), one cycle
// RUN   | stepping operand reads, held while src_valid is low
// FLUSH | last enabled array cycle consuming the final fetch
// DONE  | done pulse, accumulators held (pe_en low)
module systolic_ctrl
  import systolic_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [KW-1:0]  i_k_len,
  output logic           o_busy,
  output logic           o_done,
  systolic_if.master     io_arr
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_CLEAR = ST_CLEAR;
  localparam logic [2:0] S_RUN   = ST_RUN;
  localparam logic [2:0] S_FLUSH = ST_FLUSH;
  localparam logic [2:0] S_DONE  = ST_DONE;

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [KW-1:0]   r_k_len;
  logic [SW-1:0]   r_step;
  logic [SW-1:0]   w_step_nxt;
  logic            w_adv;
  logic            r_pe_en;
  logic            r_pe_rst_n;
  logic [N*AW-1:0] w_lane_addr;
  logic [N-1:0]    w_lane_vld;

  assign w_adv = (r_state == S_RUN) && io_arr.src_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_state_nxt = (r_k_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        w_step_nxt = r_step;
        if (w_adv) begin
          w_step_nxt = r_step + SW'(1);
          if (r_step == last_step(r_k_len)) w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_step     <= '0;
      r_k_len    <= '0;
      r_pe_en    <= 1'b0;
      r_pe_rst_n <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_step     <= w_step_nxt;
      if ((r_state == S_IDLE) && i_start) r_k_len <= clamp_k(i_k_len);
      // Buffer read latency is one cycle, so the array runs one cycle
      // behind the read strobe.
      r_pe_en    <= w_adv;
      r_pe_rst_n <= (w_state_nxt != S_CLEAR);
    end
  end

  // Addresses are registered from the next step value so they line up with
  // rd_en in the same cycle; leaving RUN zeroes them.
  skew_addr_gen u_skew (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (w_state_nxt == S_RUN),
    .i_step      (w_step_nxt),
    .i_k_len     (r_k_len),
    .o_lane_addr (w_lane_addr),
    .o_lane_vld  (w_lane_vld)
  );

  assign o_busy           = (r_state != S_IDLE);
  assign o_done           = (r_state == S_DONE);
  assign io_arr.rd_en     = w_adv;
  assign io_arr.pe_en     = r_pe_en;
  assign io_arr.pe_rst_n  = r_pe_rst_n;
  assign io_arr.lane_addr = w_lane_addr;
  assign io_arr.lane_vld  = w_lane_vld;

endmodule

// File: tb/tb_systolic_ctrl.sv
module tb_systolic_ctrl;
  import systolic_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          done;

  systolic_if bus();

  systolic_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_k_len (k_len),
    .o_busy  (busy),
    .o_done  (done),
    .io_arr  (bus)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int sc_cyc = -1;
  logic chk_en = 1'b0;

  // tile-level model
  int   g = 0;
  int   m_t0 = -1;
  int   m_k = 0;
  int   m_steps = 0;
  int   m_end = -1;
  logic m_adv_prev = 1'b0;
  logic m_rst_prev = 1'b1;

  // per-scenario logs
  logic st_a[200];
  logic sv_a[200];
  logic rs_a[200];
  logic log_busy[100];
  logic log_prst[100];
  logic log_pe_en[100];
  logic [N-1:0]    log_vld[100];
  logic [N*AW-1:0] log_addr[100];
  int done_cnt, done_cyc, mdone_cyc, rd_cnt, rd_first, rd_last;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: cycle=%0d got=%0h expected=%0h", nm, sc_cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic in_tile, is_clear, is_done, is_run, e_rd, e_prst;
    logic [N-1:0]    e_vld;
    logic [N*AW-1:0] e_addr;
    if (chk_en) begin
      in_tile  = (m_t0 >= 0);
      is_clear = in_tile && (g == m_t0 + 1);
      if (!in_tile)     is_done = 1'b0;
      else if (m_k == 0) is_done = (g == m_t0 + 2);
      else              is_done = (m_end >= 0) && (g == m_end + 2);
      is_run = in_tile && (m_k != 0) && (g >= m_t0 + 2) && (m_end < 0);
      e_rd   = is_run && bus.src_valid;
      e_prst = !(m_rst_prev || is_clear);
      e_vld  = '0;
      e_addr = '0;
      if (is_run)
        for (int i = 0; i < N; i++)
          if (m_steps >= i && (m_steps - i) < m_k) begin
            e_vld[i] = 1'b1;
            e_addr[i*AW +: AW] = AW'(m_steps - i);
          end
      chk("busy", int'(busy), int'(in_tile));
      chk("done", int'(done), int'(is_done));
      chk("rd_en", int'(bus.rd_en), int'(e_rd));
      chk("pe_en", int'(bus.pe_en), int'(m_adv_prev));
      chk("pe_rst_n", int'(bus.pe_rst_n), int'(e_prst));
      chk("lane_vld", int'(bus.lane_vld), int'(e_vld));
      chk("lane_addr", int'(bus.lane_addr), int'(e_addr));

      if (sc_cyc >= 0 && sc_cyc < 100) begin
        log_busy[sc_cyc]  = busy;
        log_prst[sc_cyc]  = bus.pe_rst_n;
        log_pe_en[sc_cyc] = bus.pe_en;
        log_vld[sc_cyc]   = bus.lane_vld;
        log_addr[sc_cyc]  = bus.lane_addr;
        if (done) begin done_cnt++; done_cyc = sc_cyc; end
        if (is_done) mdone_cyc = sc_cyc;
        if (bus.rd_en) begin
          rd_cnt++;
          if (rd_first < 0) rd_first = sc_cyc;
          rd_last = sc_cyc;
        end
      end

      if (!rst_n) begin
        m_t0 = -1; m_adv_prev = 1'b0; m_rst_prev = 1'b1;
      end else begin
        m_rst_prev = 1'b0;
        m_adv_prev = e_rd;
        if (e_rd) begin
          m_steps++;
          if (m_steps == m_k + 2 * N - 2) m_end = g;
        end
        if (is_done) m_t0 = -1;
        else if (!in_tile && start) begin
          m_t0 = g; m_k = (int'(k_len) > KMAX) ? KMAX : int'(k_len);
          m_steps = 0; m_end = -1;
        end
      end
      g++;
    end
  end

  task automatic run_cycle(input int c, input logic r, input logic s,
                           input logic [KW-1:0] k, input logic v);
    @(posedge clk); #1;
    sc_cyc = c; rst_n = r; start = s; k_len = k; bus.src_valid = v;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) run_cycle(-1, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic clear_vec();
    for (int c = 0; c < 200; c++) begin st_a[c] = 0; sv_a[c] = 1; rs_a[c] = 1; end
  endtask

  task automatic play(input int n, input logic [KW-1:0] k);
    done_cnt = 0; done_cyc = -1; mdone_cyc = -1; rd_cnt = 0; rd_first = -1; rd_last = -1;
    for (int c = 0; c < n; c++) run_cycle(c, rs_a[c], st_a[c], k, sv_a[c]);
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = '0; bus.src_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset pe_rst_n", int'(bus.pe_rst_n), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset lane_vld", int'(bus.lane_vld), 0);
    run_cycle(-1, 1'b0, 1'b0, '0, 1'b0);
    gap(3);

    // A: k=8, no stalls
    clear_vec(); st_a[0] = 1;
    play(22, 7'd8);
    chk("A pe_rst_n c1", int'(log_prst[1]), 0);
    chk("A pe_rst_n c2", int'(log_prst[2]), 1);
    chk("A rd count", rd_cnt, 14);
    chk("A rd first", rd_first, 2);
    chk("A rd last", rd_last, 15);
    chk("A done cycle", done_cyc, 17);
    chk("A model done", mdone_cyc, 17);
    chk("A done count", done_cnt, 1);
    chk("A busy c18", int'(log_busy[18]), 0);
    gap(3);

    // B: lane skew, k=3
    clear_vec(); st_a[0] = 1;
    play(16, 7'd3);
    chk("B vld s0", int'(log_vld[2]), 'b0001);
    chk("B vld s1", int'(log_vld[3]), 'b0011);
    chk("B vld s2", int'(log_vld[4]), 'b0111);
    chk("B vld s3", int'(log_vld[5]), 'b1110);
    chk("B vld s4", int'(log_vld[6]), 'b1100);
    chk("B vld s5", int'(log_vld[7]), 'b1000);
    for (int s = 3; s <= 5; s++)
      chk("B lane3 addr", int'(log_addr[s+2][3*AW +: AW]), s - 3);
    chk("B done cycle", done_cyc, 12);
    chk("B model done", mdone_cyc, 12);
    gap(3);

    // C: k=8 with src_valid low in cycles 5..7
    clear_vec(); st_a[0] = 1; sv_a[5] = 0; sv_a[6] = 0; sv_a[7] = 0;
    play(24, 7'd8);
    chk("C rd count", rd_cnt, 14);
    chk("C rd last", rd_last, 18);
    chk("C pe_en c5", int'(log_pe_en[5]), 1);
    for (int c = 6; c <= 8; c++) chk("C pe_en stall", int'(log_pe_en[c]), 0);
    chk("C pe_en c9", int'(log_pe_en[9]), 1);
    chk("C lane0 addr c5", int'(log_addr[5][AW-1:0]), 3);
    chk("C lane0 addr c8", int'(log_addr[8][AW-1:0]), 3);
    chk("C done cycle", done_cyc, 20);
    chk("C model done", mdone_cyc, 20);
    gap(3);

    // D: k=0
    clear_vec(); st_a[0] = 1;
    play(6, 7'd0);
    chk("D done cycle", done_cyc, 2);
    chk("D model done", mdone_cyc, 2);
    chk("D rd count", rd_cnt, 0);
    gap(3);

    // E: k=100 clamps to 64
    clear_vec(); st_a[0] = 1;
    play(78, 7'd100);
    chk("E done cycle", done_cyc, 73);
    chk("E model done", mdone_cyc, 73);
    chk("E rd count", rd_cnt, 70);
    gap(3);

    // F: start pulses at 4 (busy) and 17 (DONE) are ignored
    clear_vec(); st_a[0] = 1; st_a[4] = 1; st_a[17] = 1;
    play(24, 7'd8);
    chk("F done count", done_cnt, 1);
    chk("F done cycle", done_cyc, 17);
    chk("F busy c19", int'(log_busy[19]), 0);
    gap(3);

    // G: start held through DONE into IDLE -> second tile
    clear_vec(); st_a[0] = 1; st_a[17] = 1; st_a[18] = 1;
    play(40, 7'd8);
    chk("G busy c18", int'(log_busy[18]), 0);
    chk("G pe_rst_n c19", int'(log_prst[19]), 0);
    chk("G busy c19", int'(log_busy[19]), 1);
    chk("G done count", done_cnt, 2);
    chk("G done cycle", done_cyc, 35);
    chk("G model done", mdone_cyc, 35);
    gap(3);

    // H: reset in cycle 9 aborts the tile
    clear_vec(); st_a[0] = 1; rs_a[9] = 0;
    play(22, 7'd8);
    chk("H busy c9", int'(log_busy[9]), 1);
    chk("H busy c10", int'(log_busy[10]), 0);
    chk("H pe_rst_n c10", int'(log_prst[10]), 0);
    chk("H pe_en c10", int'(log_pe_en[10]), 0);
    chk("H pe_rst_n c11", int'(log_prst[11]), 1);
    chk("H done count", done_cnt, 0);
    gap(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
